// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word, RAM handshake state and memory arbiter FSM states.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  function automatic logic ram_done(input ramstate_t rs);
    return (rs == ACCESS) || (rs == ERROR);
  endfunction
endpackage

// File: rtl/memory_arbiter_if.sv
// Signal bundle between the pipeline request side, the arbiter and the RAM.
interface memory_arbiter_if (input logic CLK);
  import cpu_types_pkg::*;

  logic      nRST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore;
  logic      iwait, dwait, merr;
  word_t     iload, dload;
  logic      ramREN, ramWEN;
  word_t     ramaddr, ramstore, ramload;
  ramstate_t ramstate;

  modport arb (
    input  CLK, nRST, iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    output iwait, dwait, merr, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport tb (
    input  CLK, iwait, dwait, merr, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
    output nRST, iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate
  );
endinterface

// File: rtl/starve_counter.sv
// Saturating streak counter: clr wins over inc; sat is high once count reaches LIMIT.
module starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam logic [3:0] LIM = 4'(LIMIT);

  logic [3:0] count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && !sat)
      count <= count + 4'd1;
  end

  assign sat = (count == LIM);
endmodule

// File: rtl/memory_arbiter.sv
// Grants the single-port RAM to data (priority) or instruction requests, one
// transaction at a time, with a streak bound that guarantees fetches progress.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      iwait,
  output logic      dwait,
  output word_t     iload,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      merr
);
  arb_state_t state, next_state;
  logic       dreq, done, starved, streak_inc, streak_clr;

  assign dreq  = dREN | dWEN;
  assign done  = ram_done(ramstate);
  assign iload = ramload;
  assign dload = ramload;

  starve_counter #(.LIMIT(STARVE_LIMIT)) u_streak (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (streak_inc),
    .clr  (streak_clr),
    .sat  (starved)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = 1'b1;
    dwait      = 1'b1;
    merr       = 1'b0;
    streak_inc = 1'b0;
    streak_clr = 1'b0;
    unique case (state)
      IDLE: begin
        if (iREN && starved)
          next_state = GRANT_I;
        else if (dreq)
          next_state = GRANT_D;
        else if (iREN)
          next_state = GRANT_I;
      end
      GRANT_I: begin
        if (!iREN) begin
          next_state = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (done) begin
            iwait      = 1'b0;
            merr       = (ramstate == ERROR);
            streak_clr = 1'b1;
            next_state = IDLE;
          end
        end
      end
      GRANT_D: begin
        if (!dreq) begin
          next_state = IDLE;
        end else begin
          // a simultaneous read+write is treated as a write
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          if (done) begin
            dwait      = 1'b0;
            merr       = (ramstate == ERROR);
            streak_inc = iREN;
            streak_clr = ~iREN;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed vector table, hand sequences
// for starvation/reset corners, then random traffic against a transaction model.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int LIMIT = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  memory_arbiter_if mif (.CLK(CLK));

  memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK      (CLK),
    .nRST     (mif.nRST),
    .iREN     (mif.iREN),
    .iaddr    (mif.iaddr),
    .dREN     (mif.dREN),
    .dWEN     (mif.dWEN),
    .daddr    (mif.daddr),
    .dstore   (mif.dstore),
    .iwait    (mif.iwait),
    .dwait    (mif.dwait),
    .iload    (mif.iload),
    .dload    (mif.dload),
    .ramREN   (mif.ramREN),
    .ramWEN   (mif.ramWEN),
    .ramaddr  (mif.ramaddr),
    .ramstore (mif.ramstore),
    .ramload  (mif.ramload),
    .ramstate (mif.ramstate),
    .merr     (mif.merr)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic      iren, dren, dwen;
    ramstate_t rs;
    word_t     da, ds;
    logic      ren, wen;
    word_t     addr, store;
    logic      iw, dw, me;
  } vec_t;

  function automatic vec_t mk(input logic iren, dren, dwen, input ramstate_t rs,
                              input word_t da, ds, input logic ren, wen,
                              input word_t addr, store, input logic iw, dw, me);
    vec_t v;
    v.iren = iren; v.dren = dren; v.dwen = dwen; v.rs = rs; v.da = da; v.ds = ds;
    v.ren = ren; v.wen = wen; v.addr = addr; v.store = store;
    v.iw = iw; v.dw = dw; v.me = me;
    return v;
  endfunction

  function automatic logic [127:0] outs();
    return {57'd0, mif.ramREN, mif.ramWEN, mif.ramaddr, mif.ramstore,
            mif.iwait, mif.dwait, mif.merr};
  endfunction

  function automatic logic [127:0] pack_exp(input logic ren, wen, input word_t addr, store,
                                            input logic iw, dw, me);
    return {57'd0, ren, wen, addr, store, iw, dw, me};
  endfunction

  task automatic idle_inputs();
    mif.iREN = 0; mif.dREN = 0; mif.dWEN = 0;
    mif.iaddr = 32'h40; mif.daddr = 32'h100; mif.dstore = 0;
    mif.ramstate = FREE; mif.ramload = 32'h1234_5678;
  endtask

  task automatic do_reset();
    mif.nRST = 0;
    idle_inputs();
    @(negedge CLK);
    @(negedge CLK);
    mif.nRST = 1;
  endtask

  vec_t vecs[20];
  int   comp_q[$];
  int   owner, streak;

  initial begin
    mif.nRST = 0;
    idle_inputs();
    // Outputs must hold reset values even with requests and ACCESS present.
    mif.iREN = 1; mif.dREN = 1; mif.ramstate = ACCESS;
    #1;
    chk("reset_outputs", outs(), pack_exp(0, 0, 0, 0, 1, 1, 0));
    do_reset();

    vecs[0]  = mk(1,0,0,FREE,  32'h100,0,           0,0,0,      0,           1,1,0);
    vecs[1]  = mk(1,0,0,BUSY,  32'h100,0,           1,0,32'h40, 0,           1,1,0);
    vecs[2]  = mk(1,0,0,BUSY,  32'h100,0,           1,0,32'h40, 0,           1,1,0);
    vecs[3]  = mk(1,0,0,ACCESS,32'h100,0,           1,0,32'h40, 0,           0,1,0);
    vecs[4]  = mk(0,0,0,ACCESS,32'h100,0,           0,0,0,      0,           1,1,0);
    vecs[5]  = mk(0,1,1,FREE,  32'h200,32'hDEADBEEF,0,0,0,      0,           1,1,0);
    vecs[6]  = mk(0,1,1,FREE,  32'h200,32'hDEADBEEF,0,1,32'h200,32'hDEADBEEF,1,1,0);
    vecs[7]  = mk(0,1,1,ERROR, 32'h200,32'hDEADBEEF,0,1,32'h200,32'hDEADBEEF,1,0,1);
    vecs[8]  = mk(0,0,0,ERROR, 32'h200,0,           0,0,0,      0,           1,1,0);
    vecs[9]  = mk(1,1,0,FREE,  32'h100,0,           0,0,0,      0,           1,1,0);
    vecs[10] = mk(1,1,0,ACCESS,32'h100,0,           1,0,32'h100,0,           1,0,0);
    vecs[11] = mk(1,0,0,FREE,  32'h100,0,           0,0,0,      0,           1,1,0);
    vecs[12] = mk(1,0,0,ACCESS,32'h100,0,           1,0,32'h40, 0,           0,1,0);
    vecs[13] = mk(0,0,0,FREE,  32'h100,0,           0,0,0,      0,           1,1,0);
    vecs[14] = mk(0,1,0,FREE,  32'h100,0,           0,0,0,      0,           1,1,0);
    vecs[15] = mk(0,0,0,ACCESS,32'h100,0,           0,0,0,      0,           1,1,0);
    vecs[16] = mk(0,1,0,ACCESS,32'h100,0,           0,0,0,      0,           1,1,0);
    vecs[17] = mk(0,1,0,FREE,  32'h100,0,           1,0,32'h100,0,           1,1,0);
    vecs[18] = mk(0,0,0,FREE,  32'h100,0,           0,0,0,      0,           1,1,0);
    vecs[19] = mk(0,0,0,FREE,  32'h100,0,           0,0,0,      0,           1,1,0);

    foreach (vecs[k]) begin
      @(negedge CLK);
      mif.iREN = vecs[k].iren; mif.dREN = vecs[k].dren; mif.dWEN = vecs[k].dwen;
      mif.ramstate = vecs[k].rs; mif.daddr = vecs[k].da; mif.dstore = vecs[k].ds;
      #1;
      chk($sformatf("vec[%0d]", k), outs(),
          pack_exp(vecs[k].ren, vecs[k].wen, vecs[k].addr, vecs[k].store,
                   vecs[k].iw, vecs[k].dw, vecs[k].me));
    end

    // Starvation bound: both requesters held, RAM always answers immediately.
    do_reset();
    @(negedge CLK);
    mif.iREN = 1; mif.dREN = 1; mif.ramstate = ACCESS;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!mif.dwait) comp_q.push_back(2);
      if (!mif.iwait) comp_q.push_back(1);
      @(negedge CLK);
    end
    chk("starve_count", 128'(comp_q.size()), 128'd10);
    for (int k = 0; k < 10 && k < comp_q.size(); k++)
      chk($sformatf("starve_order[%0d]", k), 128'(comp_q[k]), (k % 5 == 4) ? 128'd1 : 128'd2);

    // Reset mid-grant drops enables asynchronously, then arbitration restarts.
    do_reset();
    @(negedge CLK);
    mif.iREN = 1; mif.ramstate = BUSY;
    #1;
    chk("rst_pre_idle", outs(), pack_exp(0, 0, 0, 0, 1, 1, 0));
    @(negedge CLK); #1;
    chk("rst_granted", outs(), pack_exp(1, 0, 32'h40, 0, 1, 1, 0));
    mif.nRST = 0;
    #1;
    chk("rst_async_drop", outs(), pack_exp(0, 0, 0, 0, 1, 1, 0));
    @(negedge CLK);
    mif.nRST = 1;
    #1;
    chk("rst_back_idle", outs(), pack_exp(0, 0, 0, 0, 1, 1, 0));
    @(negedge CLK); #1;
    chk("rst_regrant", outs(), pack_exp(1, 0, 32'h40, 0, 1, 1, 0));

    // Random traffic against a transaction-level model: owner 0=none,1=instr,2=data.
    do_reset();
    owner = 0; streak = 0;
    for (int c = 0; c < 3000; c++) begin
      logic      er, ew, eiw, edw, eme, dreq, dn;
      word_t     ea, es;
      @(negedge CLK);
      mif.iREN     = ($urandom_range(0, 9) < 6);
      mif.dREN     = ($urandom_range(0, 9) < 5);
      mif.dWEN     = ($urandom_range(0, 9) < 3);
      mif.iaddr    = $urandom;
      mif.daddr    = $urandom;
      mif.dstore   = $urandom;
      mif.ramload  = $urandom;
      mif.ramstate = ramstate_t'($urandom_range(0, 3));
      #1;
      dreq = mif.dREN | mif.dWEN;
      dn   = (mif.ramstate == ACCESS) || (mif.ramstate == ERROR);
      er = 0; ew = 0; ea = 0; es = 0; eiw = 1; edw = 1; eme = 0;
      if (owner == 1 && mif.iREN) begin
        er = 1; ea = mif.iaddr;
        if (dn) begin eiw = 0; eme = (mif.ramstate == ERROR); end
      end else if (owner == 2 && dreq) begin
        ew = mif.dWEN; er = mif.dREN && !mif.dWEN; ea = mif.daddr; es = mif.dstore;
        if (dn) begin edw = 0; eme = (mif.ramstate == ERROR); end
      end
      chk($sformatf("rand[%0d]", c), outs(), pack_exp(er, ew, ea, es, eiw, edw, eme));
      if (mif.iload !== mif.ramload || mif.dload !== mif.ramload) begin
        n_fails++;
        $display("FAIL rand_load[%0d]: iload %0h dload %0h expected %0h",
                 c, mif.iload, mif.dload, mif.ramload);
      end
      n_checks++;
      if (owner == 0) begin
        if (mif.iREN && streak == LIMIT) owner = 1;
        else if (dreq)                   owner = 2;
        else if (mif.iREN)               owner = 1;
      end else if (owner == 1) begin
        if (!mif.iREN) owner = 0;
        else if (dn) begin owner = 0; streak = 0; end
      end else begin
        if (!dreq) owner = 0;
        else if (dn) begin
          owner  = 0;
          streak = mif.iREN ? ((streak + 1 > LIMIT) ? LIMIT : streak + 1) : 0;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares the single-port RAM between the instruction-fetch and data-memory request streams of the pipeline. It sits between the datapath/cache request signals (including those produced by the request unit) and the RAM, and grants one requester at a time. Data requests have priority, and a streak counter bounds instruction starvation. Every RAM transaction is sequenced by a small FSM driven by the RAM's reported state.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive data completions allowed while an instruction fetch is pending; range 1–15.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- nRST  in  1  asynchronous, active-low reset.
- iREN  in  1  instruction read request.
- iaddr  in  32 (word_t)  instruction address.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32 (word_t)  data address.
- dstore  in  32 (word_t)  data write value.
- iwait  out  1  1 = instruction request not complete this cycle.
- dwait  out  1  1 = data request not complete this cycle.
- iload  out  32  instruction read data; equals ramload.
- dload  out  32  data read data; equals ramload.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2 (ramstate_t)  FREE, BUSY, ACCESS, ERROR.
- merr  out  1  one-cycle pulse on a RAM ERROR completion.

## Operation
- FSM states: IDLE, GRANT_I, GRANT_D. Reset state is IDLE.
- Let dreq = dREN | dWEN.
- IDLE, next state:
  - GRANT_I if iREN && dstreak == STARVE_LIMIT.
  - Otherwise GRANT_D if dreq.
  - Otherwise GRANT_I if iREN.
  - Otherwise IDLE.
- GRANT_D:
  - ramaddr = daddr, ramstore = dstore.
  - ramWEN = dWEN; ramREN = dREN & ~dWEN. Write wins when both are set.
- GRANT_I:
  - ramaddr = iaddr, ramREN = 1, ramWEN = 0, ramstore = 0.
- IDLE: ramREN = ramWEN = 0, ramaddr = 0, ramstore = 0.
- Completion: the granted state sees ramstate == ACCESS or ERROR. The granted wait goes to 0 that cycle, and the FSM moves to IDLE on the next edge.
- ERROR completion: also sets merr = 1 for that cycle only.
- iwait = ~(GRANT_I && ramstate ∈ {ACCESS, ERROR}); dwait is the same with GRANT_D. A wait is 1 whenever its requester is not completing, including when no request is asserted.
- Request withdrawn while granted (dreq = 0 in GRANT_D, or iREN = 0 in GRANT_I):
  - RAM enables are 0 that cycle and no completion is signalled.
  - FSM returns to IDLE on the next edge.
- dstreak (4-bit) update rules:
  - On a data completion with iREN = 1: increment, saturating at STARVE_LIMIT.
  - On an instruction completion: clear to 0.
  - On a data completion with iREN = 0: clear to 0.
- BUSY and FREE in a granted state: hold the grant and keep the RAM signals stable.

## Timing
- Reset values:
  - State IDLE, dstreak 0, merr 0.
  - RAM enables 0, ramaddr 0, ramstore 0.
  - iwait 1, dwait 1.
- Latency:
  - A request seen in IDLE at cycle n is presented to the RAM at cycle n+1.
  - The earliest completion is cycle n+1, when the RAM answers ACCESS combinationally.
- There is a mandatory one-cycle IDLE bubble after every completion. This prevents re-granting a request the requester has not yet retired.
- Arbitration is evaluated only in IDLE. A grant is never preempted.
- Reset asserted mid-grant: immediate return to IDLE, enables drop asynchronously, no completion is signalled.
- iload and dload are combinational pass-throughs. They are valid only in the completion cycle.

## Structure
- word_t and ramstate_t come from cpu_types_pkg.
- Add arb_state_t (IDLE, GRANT_I, GRANT_D) to cpu_types_pkg.
- Interface bundling: add memory_arbiter_if.vh with modports arb and tb.
- Sub-module: starve_counter, a saturating streak counter with inc, clr and a sat output.

## Test plan
- Instruction only: iREN = 1, iaddr = 0x40, RAM returns ACCESS after 2 BUSY cycles → ramaddr = 0x40 for 3 cycles, iwait = 0 in the 3rd, then IDLE for 1 cycle.
- Simultaneous request: iREN = 1 and dREN = 1 with daddr = 0x100 → GRANT_D first; ramaddr = 0x100; instruction is granted after the completion plus the bubble.
- Starvation bound, STARVE_LIMIT = 4: dREN and iREN held high, RAM always ACCESS → 4 data completions, then 1 instruction completion, then dstreak = 0.
- Write with both flags: dWEN = 1, dREN = 1, dstore = 0xDEADBEEF → ramWEN = 1, ramREN = 0, ramstore = 0xDEADBEEF.
- RAM ERROR: ramstate = ERROR in GRANT_D → dwait = 0, merr = 1 for exactly one cycle, IDLE next.
- Reset and withdrawal:
  - nRST pulsed low mid-GRANT_I → ramREN = 0 immediately, iwait = 1, state IDLE.
  - dREN dropped while in GRANT_D → no completion, IDLE next cycle.
